expr_gen: RTL and testbench

- Transmitter-side counterpart of the `expr` expression recognizer.
- Takes a packed request of N decimal digits and N-1 operators and serializes it as an ASCII character stream, one character per handshake, on an 8-bit bus.
- Output format: digit, op, digit, ..., digit. Digits are '0'..'9'; ops are '+' or '*'.
- Drives `expr` directly in system benches and provides a ready/valid source for any later ASCII consumer.

---
 rtl/expr_gen_if.sv | 33 +++
 rtl/expr_gen.sv | 146 ++++++++++++++
 tb/tb_expr_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/expr_gen_if.sv
`default_nettype none
// =============================================================================
// Module      : expr_gen_if
// Description : Request and ASCII ready/valid stream bundle for expr_gen.
// Revision    : 1.0
// =============================================================================
interface expr_gen_if #(
   parameter int MAX_TERMS = 4
);
   logic                   start;
   logic [2:0]             num_terms;
   logic [4*MAX_TERMS-1:0] digits;
   logic [MAX_TERMS-2:0]   ops;
   logic                   out_ready;
   logic [7:0]             out;
   logic                   out_valid;
   logic                   busy;
   logic                   done;
   logic                   err;

   // Requester and consumer side.
   modport master (
      output start, num_terms, digits, ops, out_ready,
      input  out, out_valid, busy, done, err
   );

   // Generator side.
   modport slave (
      input  start, num_terms, digits, ops, out_ready,
      output out, out_valid, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/expr_gen.sv
`default_nettype none
// =============================================================================
// Module      : expr_gen
// Description : Serializes N digits and N-1 operators as an ASCII stream.
// Revision    : 1.0
// =============================================================================
module expr_gen #(
   parameter int MAX_TERMS = 4
) (
   input  logic      clk,
   input  logic      clr,
   expr_gen_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIGIT = 2'd1,
      S_OP    = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] C_MAX_TERMS = 3'(MAX_TERMS);
   localparam logic [7:0] C_ASCII_0   = 8'h30;
   localparam logic [7:0] C_PLUS      = 8'h2B;
   localparam logic [7:0] C_MUL       = 8'h2A;

   state_t                 state_q;
   logic [2:0]             idx_q;
   logic [2:0]             n_q;
   logic [4*MAX_TERMS-1:0] digits_q;
   logic [MAX_TERMS-2:0]   ops_q;
   logic [7:0]             out_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;

   logic                   w_req_ok;
   logic [3:0]             w_next_digit;
   logic                   w_cur_op;
   logic                   w_last;
   logic [7:0]             out_d;

   always_comb begin : p_req_check
      w_req_ok = (bus.num_terms != 3'd0) && (bus.num_terms <= C_MAX_TERMS);
      for (int i = 0; i < MAX_TERMS; i++) begin
         if ((3'(i) < bus.num_terms) && (bus.digits[4*i +: 4] > 4'd9)) begin
            w_req_ok = 1'b0;
         end
      end
   end

   always_comb begin : p_select
      w_next_digit = 4'd0;
      w_cur_op     = 1'b0;
      for (int i = 0; i < MAX_TERMS; i++) begin
         if (3'(i) == (idx_q + 3'd1)) begin
            w_next_digit = digits_q[4*i +: 4];
         end
      end
      for (int i = 0; i < MAX_TERMS - 1; i++) begin
         if (3'(i) == idx_q) begin
            w_cur_op = ops_q[i];
         end
      end
   end

   assign w_last = (idx_q == (n_q - 3'd1));

   // Character presented once the current handshake (or request) completes.
   always_comb begin : p_next_char
      out_d = 8'h00;
      unique case (state_q)
         S_IDLE:  out_d = C_ASCII_0 + {4'd0, bus.digits[3:0]};
         S_DIGIT: out_d = w_last ? 8'h00 : (w_cur_op ? C_MUL : C_PLUS);
         S_OP:    out_d = C_ASCII_0 + {4'd0, w_next_digit};
         default: out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin : p_fsm
      if (clr) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         n_q         <= 3'd0;
         digits_q    <= '0;
         ops_q       <= '0;
         out_q       <= 8'h00;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_req_ok) begin
                     state_q     <= S_DIGIT;
                     idx_q       <= 3'd0;
                     n_q         <= bus.num_terms;
                     digits_q    <= bus.digits;
                     ops_q       <= bus.ops;
                     out_q       <= out_d;
                     out_valid_q <= 1'b1;
                     busy_q      <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_DIGIT: begin
               if (bus.out_ready) begin
                  out_q <= out_d;
                  if (w_last) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     state_q <= S_OP;
                  end
               end
            end
            S_OP: begin
               if (bus.out_ready) begin
                  state_q <= S_DIGIT;
                  idx_q   <= idx_q + 3'd1;
                  out_q   <= out_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_expr_gen.sv
`default_nettype none
// =============================================================================
// Module      : tb_expr_gen
// Description : Directed scoreboard bench for the expr_gen ASCII serializer.
// Revision    : 1.0
// =============================================================================
module tb_expr_gen;
   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   expr_gen_if #(.MAX_TERMS(4)) bus ();

   expr_gen #(.MAX_TERMS(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int         checks = 0;
   int         fails  = 0;
   int         n_xfer = 0;
   int         n_done = 0;
   int         n_err  = 0;
   int         x0;
   int         e0;
   int         d0;
   logic [7:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accounts for the current cycle at negedge, then moves to #1 after the next posedge.
   task automatic run_cycle();
      @(negedge clk);
      chk("done_err_exclusive", {31'd0, bus.done & bus.err}, 32'd0);
      if (!bus.out_valid) chk("out_zero_when_invalid", {24'd0, bus.out}, 32'd0);
      if (bus.done) n_done++;
      if (bus.err) n_err++;
      if (bus.out_valid && bus.out_ready && !clr) begin
         n_xfer++;
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL stream_extra_char: observed %0h expected none", bus.out);
         end else begin
            chk("stream_char", {24'd0, bus.out}, {24'd0, sb.pop_front()});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input int n, input logic [15:0] d, input logic [2:0] o);
      for (int i = 0; i < n; i++) begin
         sb.push_back(8'h30 + {4'd0, d[4*i +: 4]});
         if (i < n - 1) sb.push_back(o[i] ? 8'h2A : 8'h2B);
      end
   endtask

   task automatic drive_req(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o);
      bus.start     = 1'b1;
      bus.num_terms = n;
      bus.digits    = d;
      bus.ops       = o;
   endtask

   task automatic send(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o);
      drive_req(n, d, o);
      push_req(int'(n), d, o);
      run_cycle();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (!bus.done && k < bound) begin
         run_cycle();
         k++;
      end
      chk("done_within_bound", {31'd0, bus.done}, 32'd1);
      run_cycle();
   endtask

   task automatic bad_req(input logic [2:0] n, input logic [15:0] d);
      e0 = n_err;
      drive_req(n, d, 3'b000);
      run_cycle();
      bus.start = 1'b0;
      chk("bad_err_pulse", {31'd0, bus.err}, 32'd1);
      chk("bad_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("bad_busy", {31'd0, bus.busy}, 32'd0);
      run_cycle();
      chk("bad_err_cleared", {31'd0, bus.err}, 32'd0);
      chk("bad_err_count", n_err - e0, 32'd1);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.num_terms = 3'd0;
      bus.digits    = 16'h0000;
      bus.ops       = 3'b000;
      bus.out_ready = 1'b1;
      clr           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {24'd0, bus.out}, 32'd0);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      clr = 1'b0;
      run_cycle();

      // "1+2*3" with out_ready held high: chars in cycles 1..5, done in 6.
      x0 = n_xfer;
      send(3'd3, 16'h0321, 3'b010);
      for (int k = 1; k <= 5; k++) begin
         chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("t1_busy", {31'd0, bus.busy}, 32'd1);
         run_cycle();
      end
      chk("t1_done_c6", {31'd0, bus.done}, 32'd1);
      chk("t1_busy_c6", {31'd0, bus.busy}, 32'd1);
      chk("t1_valid_c6", {31'd0, bus.out_valid}, 32'd0);
      run_cycle();
      chk("t1_busy_c7", {31'd0, bus.busy}, 32'd0);
      chk("t1_done_c7", {31'd0, bus.done}, 32'd0);
      chk("t1_xfers", n_xfer - x0, 32'd5);
      chk("t1_sb_empty", sb.size(), 32'd0);

      // Single digit, no operator.
      x0 = n_xfer;
      send(3'd1, 16'h0007, 3'b000);
      chk("t2_valid_c1", {31'd0, bus.out_valid}, 32'd1);
      chk("t2_out_c1", {24'd0, bus.out}, 32'h37);
      run_cycle();
      chk("t2_done_c2", {31'd0, bus.done}, 32'd1);
      run_cycle();
      chk("t2_xfers", n_xfer - x0, 32'd1);

      // Backpressure on the operator character.
      x0 = n_xfer;
      send(3'd2, 16'h0094, 3'b000);
      run_cycle();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_hold_out", {24'd0, bus.out}, 32'h2B);
         chk("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
         run_cycle();
      end
      bus.out_ready = 1'b1;
      chk("t3_resume_out", {24'd0, bus.out}, 32'h2B);
      run_cycle();
      chk("t3_last_out", {24'd0, bus.out}, 32'h39);
      run_cycle();
      chk("t3_done", {31'd0, bus.done}, 32'd1);
      run_cycle();
      chk("t3_xfers", n_xfer - x0, 32'd3);
      chk("t3_sb_empty", sb.size(), 32'd0);

      // Rejected requests.
      bad_req(3'd2, 16'h00A4);
      bad_req(3'd0, 16'h0005);
      bad_req(3'd5, 16'h1111);

      // Digits beyond N are ignored even when out of range.
      send(3'd1, 16'hFFF2, 3'b111);
      chk("t4_unused_no_err", {31'd0, bus.err}, 32'd0);
      chk("t4_unused_out", {24'd0, bus.out}, 32'h32);
      wait_done(4);
      chk("t4_unused_sb_empty", sb.size(), 32'd0);

      // Reset while the second character is on the bus.
      d0 = n_done;
      send(3'd3, 16'h0321, 3'b010);
      run_cycle();
      chk("t5_second_char", {24'd0, bus.out}, 32'h2B);
      clr = 1'b1;
      run_cycle();
      clr = 1'b0;
      chk("t5_out", {24'd0, bus.out}, 32'd0);
      chk("t5_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t5_busy", {31'd0, bus.busy}, 32'd0);
      chk("t5_done", {31'd0, bus.done}, 32'd0);
      sb.delete();
      run_cycle();
      chk("t5_no_done_pulse", n_done - d0, 32'd0);
      x0 = n_xfer;
      send(3'd3, 16'h0321, 3'b010);
      wait_done(12);
      chk("t5_fresh_xfers", n_xfer - x0, 32'd5);
      chk("t5_fresh_sb_empty", sb.size(), 32'd0);

      // start while busy with a different request is ignored.
      x0 = n_xfer;
      e0 = n_err;
      send(3'd3, 16'h0321, 3'b010);
      run_cycle();
      drive_req(3'd2, 16'h0088, 3'b001);
      run_cycle();
      run_cycle();
      bus.start = 1'b0;
      wait_done(12);
      chk("t6_no_err", n_err - e0, 32'd0);
      chk("t6_xfers", n_xfer - x0, 32'd5);
      chk("t6_sb_empty", sb.size(), 32'd0);
      chk("t6_idle", {31'd0, bus.busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
